ripple_counter_ctrl: RTL and testbench
======================================

# ripple_counter_ctrl

Synchronous sequencer for the team's binary counter datapath. It accepts start, one-shot, stop and load commands over a valid/ready handshake. It runs a WIDTH-bit count against a programmable terminal value and flags terminal count and completion. It sits between the host/control logic and the counter state, and replaces free-running toggle chains wherever the count must be started, stopped, bounded or preloaded.

## Interface
- WIDTH, 4, counter and command-data width (≥1)
- PRE_W, 4, prescaler width; used only when COUNTER_CTRL_PRESCALE_EN is defined
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted this cycle
- cmd_op  in  2  00 START (free-run), 01 ONESHOT, 10 STOP, 11 LOAD
- cmd_data  in  WIDTH  terminal value for START/ONESHOT; preload value for LOAD
- hold  in  1  freeze counting while high
- prescale  in  PRE_W  tick divider, present only with COUNTER_CTRL_PRESCALE_EN
- count  out  WIDTH  current count (registered)
- busy  out  1  high in RUN_FREE or RUN_ONE
- tc_pulse  out  1  one-cycle terminal-count strobe (registered)
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN_FREE, RUN_ONE, DONE. Reset sets IDLE, count=0, limit=0, tc_pulse=0, done=0, busy=0, and the prescale counter to 0.
- cmd_ready is 1 in IDLE and DONE. In RUN_FREE/RUN_ONE, cmd_ready = (cmd_op==STOP). A command is accepted on an edge where cmd_valid & cmd_ready.
- START: limit<=cmd_data, count<=0, go to RUN_FREE.
- ONESHOT: limit<=cmd_data, count<=0, go to RUN_ONE.
- LOAD: count<=cmd_data. State is unchanged (IDLE stays IDLE; DONE stays DONE, done stays 1).
- STOP: go to IDLE, count holds its value.
- START or ONESHOT from DONE clears done.
- A tick is an edge with hold=0 in a RUN state. With the prescaler, a tick also needs the prescale counter = prescale.
- RUN_FREE tick:
  - If count==limit: count<=0 and tc_pulse<=1.
  - Else: count<=count+1.
- RUN_ONE tick:
  - If count==limit: count holds, tc_pulse<=1, go to DONE.
  - Else: count<=count+1.
- Arithmetic is unsigned mod 2^WIDTH. The limit comparison is exact equality.
- limit=0:
  - RUN_FREE: count stays 0 and tc_pulse fires every tick.
  - RUN_ONE: goes to DONE on the first tick.
- hold=1 freezes count, the prescale counter and tc_pulse generation (tc_pulse=0). STOP is still accepted during hold.
- Simultaneous STOP and terminal tick: STOP wins. State goes to IDLE, count holds, tc_pulse=0.
- rst overrides everything on any edge, including mid-run and during a handshake.

## Timing
- Command accepted at edge N: the new state, count and limit are visible after edge N.
- First tick is at edge N+1 (no prescaler, hold=0).
- START with limit L: count after successive edges is 0,1,…,L,0,…. tc_pulse is high in the cycle after the edge that wraps L→0. Period is L+1 ticks.
- ONESHOT with limit L: DONE, done=1 and tc_pulse=1 all appear after edge N+L+1. tc_pulse drops after edge N+L+2; done persists.
- busy and done are decoded from registered state, with no combinational path from inputs.
- cmd_ready depends combinationally on state and cmd_op only.

## Configuration
- COUNTER_CTRL_PRESCALE_EN defined:
  - The prescale port and a PRE_W-bit prescale counter exist.
  - A tick occurs every prescale+1 qualifying cycles.
  - The prescale counter clears on START, ONESHOT, STOP and each tick.
  - prescale=0 gives a tick every cycle.
- Not defined: no port, no counter, and every non-hold RUN cycle is a tick.

## Test plan
- Reset then idle: rst high 2 cycles → count=0, busy=0, done=0, tc_pulse=0, cmd_ready=1.
- START cmd_data=5, WIDTH=4 → count sequence 0..5,0,1,…; tc_pulse high exactly once per 6 cycles, in the cycle after 5→0.
- ONESHOT cmd_data=3 at edge N → done=1 and tc_pulse=1 after edge N+4. count stays 3. A LOAD issued during the run is not accepted (cmd_ready=0).
- hold high 3 cycles during RUN_FREE → count frozen for exactly 3 cycles. STOP issued during hold → IDLE next edge, count retained.
- ONESHOT limit 2 with STOP on the terminal edge → IDLE, tc_pulse stays 0, done=0. Follow-up LOAD 9 → count=9.
- With COUNTER_CTRL_PRESCALE_EN, prescale=2, START limit 1 → count changes every 3 cycles. rst mid-run → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ripple_counter_ctrl_if.sv
// rtl/ripple_counter_ctrl_if.sv - command handshake bundle for ripple_counter_ctrl
//
// Purpose: carries one command per accepted handshake from the host/control
// logic to the counter sequencer.
//
// Signals:
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  command can be accepted this cycle
//   cmd_op     master->slave  00 START, 01 ONESHOT, 10 STOP, 11 LOAD
//   cmd_data   master->slave  terminal value (START/ONESHOT) or preload (LOAD)
//
// Modports: master (command source), slave (sequencer side).

interface ripple_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/ripple_counter_ctrl.sv
// rtl/ripple_counter_ctrl.sv - start/stop/oneshot/load sequencer for a bounded binary counter
//
// Purpose: runs a WIDTH-bit count against a programmable terminal value,
// either free-running (wrapping at the limit) or one-shot (stopping in DONE),
// under command control over a valid/ready handshake.
//
// Optional feature macro: COUNTER_CTRL_PRESCALE_EN
//   When defined, a PRE_W-bit prescale counter and the prescale port exist and
//   a tick occurs every prescale+1 qualifying cycles. When undefined, every
//   non-hold cycle in a run state is a tick.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   cmd        slave modport of ripple_counter_ctrl_if (valid/ready/op/data)
//   hold       in   freeze counting (count, prescaler, tc_pulse) while high
//   prescale   in   tick divider (only with COUNTER_CTRL_PRESCALE_EN)
//   count      out  current count, registered
//   busy       out  high in RUN_FREE or RUN_ONE
//   tc_pulse   out  one-cycle terminal-count strobe, registered
//   done       out  high in DONE

module ripple_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ripple_counter_ctrl_if.slave  cmd,
  input  logic                  hold,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [PRE_W-1:0]      prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  done
);

  // Elaboration-time sanity check on the widths.
  if (WIDTH < 1 || PRE_W < 1) begin : g_bad_param
    $error("ripple_counter_ctrl: WIDTH and PRE_W must both be >= 1");
  end

  localparam logic [1:0] OP_START   = 2'b00;
  localparam logic [1:0] OP_ONESHOT = 2'b01;
  localparam logic [1:0] OP_STOP    = 2'b10;
  localparam logic [1:0] OP_LOAD    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_RUN_FREE = 2'b01,
    S_RUN_ONE  = 2'b10,
    S_DONE     = 2'b11
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] limit, limit_n;
  logic [WIDTH-1:0] count_n;
  logic             tc_n;
  logic             running;
  logic             accept;
  logic             pre_hit;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] pre_cnt, pre_n;
  assign pre_hit = (pre_cnt == prescale);
`else
  assign pre_hit = 1'b1;
`endif

  assign running = (state == S_RUN_FREE) || (state == S_RUN_ONE);

  // While running only STOP may enter, so a LOAD/START cannot disturb an
  // active count; ready never looks at cmd_valid or cmd_data.
  assign cmd.cmd_ready = running ? (cmd.cmd_op == OP_STOP) : 1'b1;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign busy = running;
  assign done = (state == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      limit    <= '0;
      tc_pulse <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
      pre_cnt  <= '0;
`endif
    end else begin
      count    <= count_n;
      limit    <= limit_n;
      tc_pulse <= tc_n;
`ifdef COUNTER_CTRL_PRESCALE_EN
      pre_cnt  <= pre_n;
`endif
    end
  end

  // Next-state and datapath update. An accepted command takes priority over a
  // tick; since only STOP is accepted while running, this is exactly the
  // "STOP beats a simultaneous terminal tick" rule.
  always_comb begin
    state_n = state;
    count_n = count;
    limit_n = limit;
    tc_n    = 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
    pre_n   = pre_cnt;
`endif

    if (accept) begin
      unique case (cmd.cmd_op)
        OP_START: begin
          limit_n = cmd.cmd_data;
          count_n = '0;
          state_n = S_RUN_FREE;
`ifdef COUNTER_CTRL_PRESCALE_EN
          pre_n   = '0;
`endif
        end
        OP_ONESHOT: begin
          limit_n = cmd.cmd_data;
          count_n = '0;
          state_n = S_RUN_ONE;
`ifdef COUNTER_CTRL_PRESCALE_EN
          pre_n   = '0;
`endif
        end
        OP_STOP: begin
          state_n = S_IDLE;
`ifdef COUNTER_CTRL_PRESCALE_EN
          pre_n   = '0;
`endif
        end
        OP_LOAD: begin
          // Only reachable from IDLE or DONE; state (and done) is kept.
          count_n = cmd.cmd_data;
        end
        default: begin
          state_n = state;
        end
      endcase
    end else if (running && !hold) begin
      if (pre_hit) begin
`ifdef COUNTER_CTRL_PRESCALE_EN
        pre_n = '0;
`endif
        if (count == limit) begin
          tc_n = 1'b1;
          if (state == S_RUN_FREE) begin
            count_n = '0;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          count_n = count + WIDTH'(1);
        end
      end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
        pre_n = pre_cnt + PRE_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_ripple_counter_ctrl.sv
// tb/tb_ripple_counter_ctrl.sv - self-checking bench for ripple_counter_ctrl

module tb_ripple_counter_ctrl;

  localparam int W  = 4;
  localparam int PW = 4;

  localparam int M_IDLE = 0;
  localparam int M_FREE = 1;
  localparam int M_ONE  = 2;
  localparam int M_DONE = 3;

  logic          clk;
  logic          rst;
  logic          hold;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          busy;
  logic          tc_pulse;
  logic          done;

  ripple_counter_ctrl_if #(.WIDTH(W)) cif ();

  ripple_counter_ctrl #(.WIDTH(W), .PRE_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cif.slave),
    .hold     (hold),
`ifdef COUNTER_CTRL_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .busy     (busy),
    .tc_pulse (tc_pulse),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: behaviour described as mode + plain integer arithmetic.
  int m_mode, m_cnt, m_lim, m_div;
  bit m_tc;

  function automatic bit model_ready(input logic [1:0] op);
    if (m_mode == M_FREE || m_mode == M_ONE) return (op == 2'b10);
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [1:0] op,
                            input logic [W-1:0] d, input logic h);
    bit acc;
    acc  = v && model_ready(op);
    m_tc = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_cnt = 0; m_lim = 0; m_div = 0;
    end else if (acc) begin
      case (op)
        2'b00: begin m_lim = int'(d); m_cnt = 0; m_mode = M_FREE; m_div = 0; end
        2'b01: begin m_lim = int'(d); m_cnt = 0; m_mode = M_ONE;  m_div = 0; end
        2'b10: begin m_mode = M_IDLE; m_div = 0; end
        default: m_cnt = int'(d);
      endcase
    end else if ((m_mode == M_FREE || m_mode == M_ONE) && !h) begin
      if (m_div == int'(prescale)) begin
        m_div = 0;
        if (m_cnt == m_lim) begin
          m_tc = 1'b1;
          if (m_mode == M_FREE) m_cnt = 0;
          else m_mode = M_DONE;
        end else begin
          m_cnt = (m_cnt + 1) % (1 << W);
        end
      end else begin
        m_div = (m_div + 1) % (1 << PW);
      end
    end
  endtask

  // One clock: drive inputs, sample cmd_ready before the edge, update model,
  // then let the edge happen and settle.
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [W-1:0] d, input logic h,
                      output logic rdy_act, output logic rdy_mod);
    rst           = r;
    cif.cmd_valid = v;
    cif.cmd_op    = op;
    cif.cmd_data  = d;
    hold          = h;
    #1;
    rdy_act = cif.cmd_ready;
    rdy_mod = model_ready(op);
    model_step(r, v, op, d, h);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".busy"},  32'(busy),  32'(m_mode == M_FREE || m_mode == M_ONE));
    chk({tag, ".done"},  32'(done),  32'(m_mode == M_DONE));
    chk({tag, ".tc"},    32'(tc_pulse), 32'(m_tc));
  endtask

  typedef struct {
    logic         r;
    logic         v;
    logic [1:0]   op;
    logic [W-1:0] d;
    logic         h;
    logic [W-1:0] e_cnt;
    logic         e_busy;
    logic         e_done;
    logic         e_tc;
    logic         e_rdy;
    logic         chk_rdy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [1:0] op, input int d,
                     input logic h, input int e_cnt, input logic e_busy,
                     input logic e_done, input logic e_tc, input logic e_rdy,
                     input logic chk_rdy);
    vec_t t;
    t.r = r; t.v = v; t.op = op; t.d = W'(d); t.h = h;
    t.e_cnt = W'(e_cnt); t.e_busy = e_busy; t.e_done = e_done; t.e_tc = e_tc;
    t.e_rdy = e_rdy; t.chk_rdy = chk_rdy;
    vq.push_back(t);
  endtask

  logic ra, rm;

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; hold = 1'b0; prescale = '0;
    cif.cmd_valid = 1'b0; cif.cmd_op = 2'b00; cif.cmd_data = '0;
    m_mode = M_IDLE; m_cnt = 0; m_lim = 0; m_div = 0; m_tc = 1'b0;

    //  r  v  op     d  h   cnt bsy dn tc rdy chk
    add(1, 0, 2'b00, 0, 0,  0,  0,  0, 0, 1,  0);  // reset
    add(1, 0, 2'b00, 0, 0,  0,  0,  0, 0, 1,  1);
    add(0, 0, 2'b00, 0, 0,  0,  0,  0, 0, 1,  1);  // idle
    add(0, 1, 2'b00, 5, 0,  0,  1,  0, 0, 1,  1);  // START 5
    add(0, 0, 2'b00, 0, 0,  1,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  2,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  3,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  4,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  5,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  0,  1,  0, 1, 0,  1);  // wrap 5->0
    add(0, 0, 2'b00, 0, 0,  1,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  2,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 1,  2,  1,  0, 0, 0,  1);  // hold x3
    add(0, 0, 2'b00, 0, 1,  2,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 1,  2,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  3,  1,  0, 0, 0,  1);
    add(0, 1, 2'b10, 0, 1,  3,  0,  0, 0, 1,  1);  // STOP under hold
    add(0, 0, 2'b00, 0, 0,  3,  0,  0, 0, 1,  1);
    add(0, 1, 2'b01, 3, 0,  0,  1,  0, 0, 1,  1);  // ONESHOT 3
    add(0, 1, 2'b11, 9, 0,  1,  1,  0, 0, 0,  1);  // LOAD refused
    add(0, 0, 2'b00, 0, 0,  2,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  3,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  3,  0,  1, 1, 0,  1);  // DONE after N+4
    add(0, 0, 2'b00, 0, 0,  3,  0,  1, 0, 1,  1);
    add(0, 1, 2'b11, 7, 0,  7,  0,  1, 0, 1,  1);  // LOAD in DONE
    add(0, 1, 2'b01, 2, 0,  0,  1,  0, 0, 1,  1);  // ONESHOT 2
    add(0, 0, 2'b00, 0, 0,  1,  1,  0, 0, 0,  1);
    add(0, 0, 2'b00, 0, 0,  2,  1,  0, 0, 0,  1);
    add(0, 1, 2'b10, 0, 0,  2,  0,  0, 0, 1,  1);  // STOP on terminal edge
    add(0, 1, 2'b11, 9, 0,  9,  0,  0, 0, 1,  1);  // LOAD 9
    add(0, 1, 2'b00, 0, 0,  0,  1,  0, 0, 1,  1);  // START 0
    add(0, 0, 2'b00, 0, 0,  0,  1,  0, 1, 0,  1);
    add(0, 0, 2'b00, 0, 0,  0,  1,  0, 1, 0,  1);
    add(0, 0, 2'b00, 0, 0,  0,  0,  0, 0, 0,  1);  // rst mid-run
    add(0, 0, 2'b00, 0, 0,  0,  0,  0, 0, 1,  1);
    vq[33].r = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].v, vq[i].op, vq[i].d, vq[i].h, ra, rm);
      if (vq[i].chk_rdy) chk($sformatf("vec%0d.rdy", i), 32'(ra), 32'(vq[i].e_rdy));
      chk($sformatf("vec%0d.count", i), 32'(count),    32'(vq[i].e_cnt));
      chk($sformatf("vec%0d.busy", i),  32'(busy),     32'(vq[i].e_busy));
      chk($sformatf("vec%0d.done", i),  32'(done),     32'(vq[i].e_done));
      chk($sformatf("vec%0d.tc", i),    32'(tc_pulse), 32'(vq[i].e_tc));
    end

`ifdef COUNTER_CTRL_PRESCALE_EN
    begin
      int exp_p[9];
      int exp_t[9];
      exp_p = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
      exp_t = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
      prescale = 4'd2;
      step(0, 1, 2'b00, 1, 0, ra, rm);
      chk("pre.start.count", 32'(count), 32'd0);
      for (int k = 0; k < 9; k++) begin
        step(0, 0, 2'b00, 0, 0, ra, rm);
        chk($sformatf("pre%0d.count", k), 32'(count), 32'(exp_p[k]));
        chk($sformatf("pre%0d.tc", k),    32'(tc_pulse), 32'(exp_t[k]));
      end
      step(1, 0, 2'b00, 0, 0, ra, rm);
      chk("pre.rst.count", 32'(count), 32'd0);
      chk("pre.rst.busy",  32'(busy),  32'd0);
      chk("pre.rst.tc",    32'(tc_pulse), 32'd0);
      chk("pre.rst.done",  32'(done),  32'd0);
    end
`endif

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic r, v, h;
      logic [1:0] op;
      logic [W-1:0] d;
      r  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 2) == 0);
      op = 2'($urandom_range(0, 3));
      d  = W'($urandom_range(0, 7));
      h  = ($urandom_range(0, 4) == 0);
`ifdef COUNTER_CTRL_PRESCALE_EN
      if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 2));
`endif
      step(r, v, op, d, h, ra, rm);
      chk($sformatf("rnd%0d.rdy", i), 32'(ra), 32'(rm));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
